// File: rtl/ram_responder_if.sv
// Request/acknowledge bundle between the CPU control FSM (master) and the
// RAM responder (slave). operation/address/data_in are level-held by the master.
interface ram_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [1:0]        operation;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              busy;

  modport master (
    output operation,
    output address,
    output data_in,
    input  data_out,
    input  done,
    input  busy
  );

  modport slave (
    input  operation,
    input  address,
    input  data_in,
    output data_out,
    output done,
    output busy
  );
endinterface

// File: rtl/ram_responder.sv
// Memory-side responder: DEPTH x DATA_W register file serving one level-coded
// request at a time (IDLE/GET/SET/RESET) with a four-phase done handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_INIT  | post-reset clear sweep, one word per cycle, no done
// S_IDLE  | waiting; samples operation every edge, latches operands
// S_READ  | data_out <= mem[addr_q]
// S_WRITE | mem[addr_q] <= data_q
// S_CLEAR | RESET request sweep; data_out <= 0 on the last word
// S_ACK   | done high until the initiator returns operation to IDLE
module ram_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_responder_if.slave bus
);

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_GET   = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WRITE,
    S_CLEAR,
    S_ACK
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_out_q;
  logic              done_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Out-of-range addresses read as zero and drop writes.
  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);

  // Write port select: sweeps write zero at ptr, SET writes the latched operand.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = '0;
    case (state)
      S_INIT, S_CLEAR: begin
        mem_we = 1'b1;
      end
      S_WRITE: begin
        mem_we    = in_range;
        mem_waddr = addr_q;
        mem_wdata = data_q;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Storage has no reset of its own; S_INIT clears it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Request sequencing, operand capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      ptr        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (ptr == PTR_LAST) begin
            ptr   <= '0;
            state <= S_IDLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_IDLE: begin
          case (bus.operation)
            OP_GET: begin
              addr_q <= bus.address;
              state  <= S_READ;
            end
            OP_SET: begin
              addr_q <= bus.address;
              data_q <= bus.data_in;
              state  <= S_WRITE;
            end
            OP_RESET: begin
              ptr   <= '0;
              state <= S_CLEAR;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_READ: begin
          data_out_q <= in_range ? mem[addr_q] : '0;
          done_q     <= 1'b1;
          state      <= S_ACK;
        end
        S_WRITE: begin
          done_q <= 1'b1;
          state  <= S_ACK;
        end
        S_CLEAR: begin
          if (ptr == PTR_LAST) begin
            ptr        <= '0;
            data_out_q <= '0;
            done_q     <= 1'b1;
            state      <= S_ACK;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_ACK: begin
          // Any non-IDLE code, even a different one, keeps the handshake parked.
          if (bus.operation == OP_IDLE) begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          done_q <= 1'b0;
          ptr    <= '0;
          state  <= S_INIT;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed scenarios with a read scoreboard fed from
// a word-level model of the array.
module tb_ram_responder;

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_GET   = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  logic clk;
  logic rst_n;

  ram_responder_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  ram_responder #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model [16];
  logic [15:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and wait for done; edges = -1 when done never came.
  task automatic issue(input logic [1:0] op, input logic [3:0] a,
                       input logic [15:0] d, output int edges);
    bus.operation = op;
    bus.address   = a;
    bus.data_in   = d;
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!bus.done && edges < 100);
    if (!bus.done) edges = -1;
  endtask

  task automatic release_op(output logic done_after);
    bus.operation = OP_IDLE;
    tick();
    done_after = bus.done;
  endtask

  // GET with scoreboard: expected value pushed at issue, popped at done.
  task automatic get_check(input logic [3:0] a, input string name);
    int e;
    logic d;
    logic [15:0] exp_v;
    exp_q.push_back(model[a]);
    issue(OP_GET, a, 16'h0, e);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (e !== 2) $display("FAIL %s_latency: got %0d edges, want 2", name, e);
    else n_pass++;
    n_checks++;
    if (bus.data_out !== exp_v)
      $display("FAIL %s_data: got %h, want %h", name, bus.data_out, exp_v);
    else n_pass++;
    release_op(d);
    n_checks++;
    if (d !== 1'b0) $display("FAIL %s_done_drop: got %b, want 0", name, d);
    else n_pass++;
  endtask

  task automatic set_word(input logic [3:0] a, input logic [15:0] v);
    int e;
    logic d;
    issue(OP_SET, a, v, e);
    model[a] = v;
    release_op(d);
    if (e < 0) begin
      n_checks++;
      $display("FAIL set_timeout: got no done, want done for addr %0d", a);
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic saw_done;
    rst_n = 1'b0;
    bus.operation = OP_IDLE;
    bus.address = '0;
    bus.data_in = '0;
    repeat (2) tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.data_out !== 16'h0)
      $display("FAIL reset_values: got busy=%b done=%b data=%h, want 1 0 0000",
               bus.busy, bus.done, bus.data_out);
    else n_pass++;
    rst_n = 1'b1;
    cnt = 0;
    saw_done = 1'b0;
    do begin
      tick();
      cnt++;
      if (bus.done) saw_done = 1'b1;
    end while (bus.busy && cnt < 40);
    n_checks++;
    if (cnt !== 16) $display("FAIL init_busy_len: got %0d, want 16", cnt);
    else n_pass++;
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL init_no_done: got done=1, want 0");
    else n_pass++;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    get_check(4'd5, "init_get5");
  endtask

  task automatic test_set_get();
    int e;
    logic d;
    issue(OP_SET, 4'd3, 16'h1234, e);
    model[3] = 16'h1234;
    n_checks++;
    if (e !== 2) $display("FAIL set_latency: got %0d edges, want 2", e);
    else n_pass++;
    release_op(d);
    n_checks++;
    if (d !== 1'b0) $display("FAIL set_done_drop: got %b, want 0", d);
    else n_pass++;
    get_check(4'd3, "raw_get3");
  endtask

  task automatic test_protocol();
    int e;
    logic stable;
    logic [15:0] held;
    set_word(4'd4, 16'h4444);
    issue(OP_GET, 4'd3, 16'h0, e);
    held = bus.data_out;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done !== 1'b1 || bus.data_out !== held) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1 || held !== 16'h1234)
      $display("FAIL ack_hold: got stable=%b data=%h, want 1 1234", stable, held);
    else n_pass++;
    bus.operation = OP_SET;
    bus.address   = 4'd4;
    bus.data_in   = 16'hBEEF;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) $display("FAIL ack_switch_done: got done dropped, want held 1");
    else n_pass++;
    bus.operation = OP_IDLE;
    tick();
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL ack_idle_drop: got %b, want 0", bus.done);
    else n_pass++;
    get_check(4'd4, "no_write_addr4");
  endtask

  task automatic test_clear();
    int e;
    logic d;
    for (int i = 0; i < 16; i++) set_word(4'(i), 16'hA000 + 16'(i));
    get_check(4'd10, "fill_get10");
    issue(OP_RESET, 4'd0, 16'h0, e);
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    n_checks++;
    if (e !== 17) $display("FAIL clear_latency: got %0d edges, want 17", e);
    else n_pass++;
    n_checks++;
    if (bus.data_out !== 16'h0) $display("FAIL clear_data_out: got %h, want 0000", bus.data_out);
    else n_pass++;
    release_op(d);
    get_check(4'd0, "clear_get0");
    get_check(4'd7, "clear_get7");
    get_check(4'd15, "clear_get15");
  endtask

  task automatic test_operand_capture();
    int e;
    logic d;
    set_word(4'd9, 16'h5555);
    bus.operation = OP_SET;
    bus.address   = 4'd3;
    bus.data_in   = 16'h1111;
    tick();
    bus.address = 4'd9;
    bus.data_in = 16'h2222;
    e = 1;
    while (!bus.done && e < 100) begin
      tick();
      e++;
    end
    model[3] = 16'h1111;
    n_checks++;
    if (e !== 2) $display("FAIL capture_latency: got %0d edges, want 2", e);
    else n_pass++;
    release_op(d);
    get_check(4'd3, "capture_get3");
    get_check(4'd9, "capture_get9");
  endtask

  task automatic test_back_to_back();
    int e;
    logic d;
    issue(OP_SET, 4'd6, 16'hCAFE, e);
    model[6] = 16'hCAFE;
    release_op(d);
    get_check(4'd6, "b2b_get6");
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic saw_done;
    set_word(4'd2, 16'h7777);
    set_word(4'd12, 16'h7A7A);
    get_check(4'd12, "pre_mid_get12");
    bus.operation = OP_RESET;
    tick();
    repeat (6) tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL mid_sweep: got done=%b busy=%b, want 0 1", bus.done, bus.busy);
    else n_pass++;
    rst_n = 1'b0;
    bus.operation = OP_GET;
    bus.address   = 4'd2;
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.data_out !== 16'h0 || bus.busy !== 1'b1)
      $display("FAIL mid_reset_async: got done=%b data=%h busy=%b, want 0 0000 1",
               bus.done, bus.data_out, bus.busy);
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    cnt = 0;
    saw_done = 1'b0;
    do begin
      tick();
      cnt++;
      if (bus.done) saw_done = 1'b1;
    end while (bus.busy && cnt < 40);
    n_checks++;
    if (cnt !== 16 || saw_done !== 1'b0)
      $display("FAIL mid_reinit: got %0d busy edges done_seen=%b, want 16 0", cnt, saw_done);
    else n_pass++;
    get_check(4'd2, "held_get2");
    get_check(4'd12, "mid_get12");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.operation = OP_IDLE;
    bus.address = '0;
    bus.data_in = '0;
    test_reset();
    test_set_get();
    test_protocol();
    test_clear();
    test_operand_capture();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the mini-CPU's 2-bit level-coded RAM request interface: IDLE, GET, SET, RESET.
- Holds a DEPTH x DATA_W register file and services one request at a time.
- Acknowledges each request with a four-phase `done` handshake.
- Sits between the CPU control FSM and storage; `data_out` also feeds the LCD display path directly.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words (DEPTH <= 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- operation  in  2  request code, level-held by the initiator: 0=IDLE, 1=GET, 2=SET, 3=RESET.
- address  in  ADDR_W  word address for GET/SET.
- data_in  in  DATA_W  write data for SET.
- data_out  out  DATA_W  read data; holds its value between requests.
- done  out  1  request-complete acknowledge.
- busy  out  1  high whenever the FSM is not in S_IDLE.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=S_INIT, done=0, data_out=0, busy=1, sweep pointer=0, address/data latches=0.
- rst_n does not clear the array directly; S_INIT performs the clear sweep.

States:
- S_INIT: writes mem[ptr]=0 each cycle, ptr++. After writing DEPTH-1, goes to S_IDLE. No done pulse. Any operation present during INIT is ignored until S_IDLE is reached; it is then sampled normally because operation is level-held.
- S_IDLE: samples operation at each edge.
  - GET: latch address, go to S_READ.
  - SET: latch address and data_in, go to S_WRITE.
  - RESET: ptr=0, go to S_CLEAR.
  - IDLE: stay.
- S_READ: data_out <= mem[addr_q] (0 if addr_q >= DEPTH); go to S_ACK.
- S_WRITE: mem[addr_q] <= data_q (ignored if addr_q >= DEPTH); data_out unchanged; go to S_ACK.
- S_CLEAR: mem[ptr] <= 0, ptr++. At ptr==DEPTH-1, write, set data_out <= 0, go to S_ACK. Takes DEPTH cycles.
- S_ACK: done=1 (registered, asserted on entry).
  - Stays in S_ACK while operation != IDLE, including a different non-IDLE code. A new request requires a return to IDLE first.
  - On sampling operation==IDLE: go to S_IDLE; done=0 on that same edge.

Latency, measured from the edge that samples the request in S_IDLE to done high:
- GET/SET: 2 edges.
- RESET: DEPTH+1 edges.
- Back-to-back minimum: operation low for 1 cycle in S_ACK, then the new request is sampled on the following edge from S_IDLE.

Operand and data rules:
- address and data_in are captured only in S_IDLE. Later changes during the request have no effect.
- Read-after-write to the same address returns the newly written value.
- data_out changes only in S_READ, in S_CLEAR completion, and on reset.

Reset mid-operation:
- Immediate return to S_INIT with done=0, data_out=0.
- The sweep restarts from 0.
- A partially completed SET may or may not have landed; the sweep overwrites it regardless.

busy = (state != S_IDLE); combinational from the state register.

Test Plan:
- Reset release, operation=IDLE -> busy high 16 cycles, then 0. done never asserts. A subsequent GET at address 5 returns 0x0000.
- SET addr=3, data=0x1234, hold until done, then IDLE -> done high exactly 2 edges after sampling. GET addr=3 -> data_out=0x1234, done 2 edges after sampling.
- Protocol check: after done=1, hold GET 10 extra cycles -> done stays 1 and data_out stable. Switch directly to SET addr=4 without IDLE -> no write to addr 4, done stays 1. Drop to IDLE -> done=0 next edge.
- Fill addr 0..15 with 0xA000+addr, issue RESET -> done after 17 edges, data_out=0. GETs of addresses 0, 7, 15 all return 0.
- Change address and data_in from 3/0x1111 to 9/0x2222 one cycle after SET is sampled -> only mem[3]=0x1111. mem[9] unchanged.
- Assert rst_n low during a RESET sweep at ptr=6, release -> 16-cycle INIT sweep, done stays 0. A held GET addr=2 is serviced after INIT and returns 0.
